// File: rtl/serial_addsub_ctrl.sv
// Serial 16-bit add/subtract/packed-saturating-add controller built around
// a single 4-bit add/sub slice that is time-multiplexed over four nibbles.

module add_sub_4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       ovfl_o,
  output logic       cout_o
);

  logic [4:0] full;

  assign full   = {1'b0, a_i} + {1'b0, b_i} + {4'd0, cin_i};
  assign sum_o  = full[3:0];
  assign cout_o = full[4];
  // Signed overflow: equal operand signs but the sum sign differs.
  assign ovfl_o = (a_i[3] == b_i[3]) && (sum_o[3] != a_i[3]);

endmodule

module serial_addsub_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        flag_z,
  output logic        flag_v,
  output logic        flag_n,
  output logic        err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] OP_ADD    = 2'b00;
  localparam logic [1:0] OP_SUB    = 2'b01;
  localparam logic [1:0] OP_PADDSB = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  logic [1:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        carry_q, carry_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] work_q, work_d;
  logic [15:0] result_q, result_d;
  logic        z_q, z_d;
  logic        v_q, v_d;
  logic        n_q, n_d;

  logic [3:0]  aNib, bNib, sliceB, sliceSum, nibOut;
  logic        sliceCin, sliceOvfl, sliceCout;
  logic [15:0] rawFull, satFull;

  assign aNib   = a_q[{cnt_q, 2'b00} +: 4];
  assign bNib   = b_q[{cnt_q, 2'b00} +: 4];
  assign sliceB = (op_q == OP_SUB) ? ~bNib : bNib;

  // Nibble 0 seeds the carry chain; PADDSB and reserved ops never chain.
  always_comb begin
    sliceCin = 1'b0;
    case (op_q)
      OP_ADD:  sliceCin = (cnt_q == 2'd0) ? 1'b0 : carry_q;
      OP_SUB:  sliceCin = (cnt_q == 2'd0) ? 1'b1 : carry_q;
      default: sliceCin = 1'b0;
    endcase
  end

  add_sub_4 u_slice (
    .a_i    (aNib),
    .b_i    (sliceB),
    .cin_i  (sliceCin),
    .sum_o  (sliceSum),
    .ovfl_o (sliceOvfl),
    .cout_o (sliceCout)
  );

  assign nibOut  = ((op_q == OP_PADDSB) && sliceOvfl)
                   ? (sliceSum[3] ? 4'h7 : 4'h8) : sliceSum;
  assign rawFull = {nibOut, work_q[11:0]};
  assign satFull = sliceOvfl ? (sliceSum[3] ? 16'h7FFF : 16'h8000) : rawFull;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    work_d   = work_q;
    result_d = result_q;
    z_d      = z_q;
    v_d      = v_q;
    n_d      = n_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          op_d    = op;
          cnt_d   = 2'd0;
          carry_d = 1'b0;
          work_d  = 16'h0000;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        work_d[{cnt_q, 2'b00} +: 4] = nibOut;
        carry_d = sliceCout;
        cnt_d   = cnt_q + 2'd1;
        // Last nibble: publish the result and, for ADD/SUB only, the flags.
        if (cnt_q == 2'd3) begin
          state_d = DONE;
          case (op_q)
            OP_ADD, OP_SUB: begin
              result_d = satFull;
              z_d      = (satFull == 16'h0000);
              n_d      = satFull[15];
              v_d      = sliceOvfl;
            end
            OP_PADDSB: result_d = rawFull;
            default:   result_d = 16'h0000;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      carry_q  <= 1'b0;
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      op_q     <= OP_ADD;
      work_q   <= 16'h0000;
      result_q <= 16'h0000;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
      n_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      work_q   <= work_d;
      result_q <= result_d;
      z_q      <= z_d;
      v_q      <= v_d;
      n_q      <= n_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign err    = (state_q == DONE) && (op_q == OP_RSVD);
  assign result = result_q;
  assign flag_z = z_q;
  assign flag_v = v_q;
  assign flag_n = n_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed self-checking bench for serial_addsub_ctrl; every expected value
// below is worked out by hand from the nibble-serial arithmetic.

module tb_serial_addsub_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        flag_z;
  logic        flag_v;
  logic        flag_n;
  logic        err;

  int errors;
  int checks;

  serial_addsub_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .result (result),
    .flag_z (flag_z),
    .flag_v (flag_v),
    .flag_n (flag_n),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts one operation and waits (bounded) for done; operands are
  // scrambled right after acceptance, which must not affect the result.
  // Entered and left #1 after a rising edge; lat = edges after the start edge.
  task automatic runOp(input logic [1:0] o, input logic [15:0] a,
                       input logic [15:0] b, output int lat);
    op = o; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = o ^ 2'b01; A = ~a; B = a ^ b;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; op = 2'b00; A = 16'h1111; B = 16'h2222;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: busy/done/err=%b expected 000", {busy, done, err});
    end
    checks++;
    if (result !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_result: got %h expected 0000", result);
    end
    checks++;
    if ({flag_z, flag_v, flag_n} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_flags: zvn=%b expected 000", {flag_z, flag_v, flag_n});
    end
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add;
    int lat;
    runOp(2'b00, 16'h1234, 16'h0FFF, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("[TB] FAIL add_latency: got %0d expected 4", lat);
    end
    checks++;
    if (result !== 16'h2233) begin
      errors++;
      $display("[TB] FAIL add_result: got %h expected 2233", result);
    end
    checks++;
    if ({flag_z, flag_v, flag_n, err} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL add_flags: zvn,err=%b expected 0000", {flag_z, flag_v, flag_n, err});
    end
    @(posedge clk); #1;
    checks++;
    if ({done, busy} !== 2'b00 || result !== 16'h2233) begin
      errors++;
      $display("[TB] FAIL add_done_width: done/busy=%b result=%h expected 00/2233", {done, busy}, result);
    end
    runOp(2'b00, 16'h7FFF, 16'h0001, lat);
    checks++;
    if (result !== 16'h7FFF || {flag_z, flag_v, flag_n} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL add_sat: got %h zvn=%b expected 7fff 010", result, {flag_z, flag_v, flag_n});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sub;
    int lat;
    runOp(2'b01, 16'h8000, 16'h0001, lat);
    checks++;
    if (result !== 16'h8000 || {flag_z, flag_v, flag_n} !== 3'b011) begin
      errors++;
      $display("[TB] FAIL sub_sat: got %h zvn=%b expected 8000 011", result, {flag_z, flag_v, flag_n});
    end
    @(posedge clk); #1;
    runOp(2'b01, 16'h0005, 16'h0005, lat);
    checks++;
    if (lat !== 4 || result !== 16'h0000 || {flag_z, flag_v, flag_n} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL sub_zero: lat=%0d got %h zvn=%b expected 4 0000 100", lat, result, {flag_z, flag_v, flag_n});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_paddsb;
    int lat;
    runOp(2'b00, 16'hFFFF, 16'h0000, lat);
    checks++;
    if (result !== 16'hFFFF || {flag_z, flag_v, flag_n} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL paddsb_preset: got %h zvn=%b expected ffff 001", result, {flag_z, flag_v, flag_n});
    end
    @(posedge clk); #1;
    runOp(2'b10, 16'h7788, 16'h1188, lat);
    checks++;
    if (result !== 16'h7788) begin
      errors++;
      $display("[TB] FAIL paddsb_sat: got %h expected 7788", result);
    end
    checks++;
    if ({flag_z, flag_v, flag_n, err} !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL paddsb_flags_held: zvn,err=%b expected 0010", {flag_z, flag_v, flag_n, err});
    end
    @(posedge clk); #1;
    runOp(2'b10, 16'h1234, 16'h4321, lat);
    checks++;
    if (result !== 16'h5555 || lat !== 4) begin
      errors++;
      $display("[TB] FAIL paddsb_plain: got %h lat=%0d expected 5555 4", result, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reserved;
    int lat;
    runOp(2'b00, 16'hFFFF, 16'h0000, lat);
    @(posedge clk); #1;
    runOp(2'b11, 16'h1234, 16'h5678, lat);
    checks++;
    if (lat !== 4 || result !== 16'h0000 || err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rsvd_result: lat=%0d got %h err=%b expected 4 0000 1", lat, result, err);
    end
    checks++;
    if ({flag_z, flag_v, flag_n} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL rsvd_flags_held: zvn=%b expected 001", {flag_z, flag_v, flag_n});
    end
    @(posedge clk); #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rsvd_err_width: err=%b expected 0", err);
    end
  endtask

  task automatic test_abort;
    int lat;
    bit sawDone;
    // Leave nonzero result and flags behind so the abort has something to clear.
    runOp(2'b00, 16'hFFFF, 16'h0000, lat);
    @(posedge clk); #1;
    op = 2'b00; A = 16'h0101; B = 16'h0202; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; A = 16'h4444; B = 16'h4444;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_start_ignored: busy=%b done=%b expected 1 0", busy, done);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || result !== 16'h0000 || {flag_z, flag_v, flag_n} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL abort_clear: busy=%b result=%h zvn=%b expected 0 0000 000", busy, result, {flag_z, flag_v, flag_n});
    end
    sawDone = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) sawDone = 1'b1;
    end
    checks++;
    if (sawDone !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_no_done: done seen=%b expected 0", sawDone);
    end
    runOp(2'b00, 16'h0101, 16'h0202, lat);
    checks++;
    if (lat !== 4 || result !== 16'h0303) begin
      errors++;
      $display("[TB] FAIL abort_restart: lat=%0d got %h expected 4 0303", lat, result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int lat1;
    int lat2;
    op = 2'b10; A = 16'h1111; B = 16'h2222; start = 1'b1;
    @(posedge clk); #1;
    op = 2'b01; A = 16'h0010; B = 16'h0001;
    lat1 = 0;
    while (!done && lat1 < 20) begin
      @(posedge clk); #1;
      lat1++;
    end
    checks++;
    if (lat1 !== 4 || result !== 16'h3333) begin
      errors++;
      $display("[TB] FAIL b2b_first: lat=%0d got %h expected 4 3333", lat1, result);
    end
    lat2 = 0;
    @(posedge clk); #1;
    lat2++;
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_gap: done=%b busy=%b expected 0 1", done, busy);
    end
    while (!done && lat2 < 20) begin
      @(posedge clk); #1;
      lat2++;
    end
    checks++;
    if (lat2 !== 5 || result !== 16'h000F || {flag_z, flag_v, flag_n} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL b2b_second: spacing=%0d got %h zvn=%b expected 5 000f 000", lat2, result, {flag_z, flag_v, flag_n});
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_end: done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1; start = 1'b0; op = 2'b00; A = 16'h0000; B = 16'h0000;
    test_reset();
    test_add();
    test_sub();
    test_paddsb();
    test_reserved();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
